// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front end: one outstanding req/ack fetch into a DEPTH-entry queue, decode drains via valid/ready.
// Ack-to-inst_valid latency 1 cycle; issue stalls when queued + in-flight reaches DEPTH; redirect flushes the queue.
// Optional IPQ_PERF_EN macro adds fetch_count/flush_count performance counter ports.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready
`ifdef IPQ_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [29:0]     mem_addr_q, mem_addr_d;
    logic [29:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_after;
    logic            push;
    logic            pop;

    logic [31:0]     inst_mem [DEPTH];
    logic [29:0]     pc_mem   [DEPTH];

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready & ~redirect;
    assign push       = (state_q == WAIT) & mem_ack & ~redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            // The outstanding request, if any, must still finish its handshake.
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc;
            case (state_q)
                WAIT: begin
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            count_d = count_after;
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case (state_q)
                IDLE: begin
                    if (count_after < CW'(DEPTH)) begin
                        state_d    = WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc_d = fetch_pc_q + 30'd1;
                        if (count_after < CW'(DEPTH)) begin
                            mem_addr_d = fetch_pc_q + 30'd1;
                        end else begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            inst_mem[tail_q] <= mem_rdata;
            pc_mem[tail_q]   <= mem_addr_q;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign inst     = inst_valid ? inst_mem[head_q] : 32'd0;
    assign inst_pc  = inst_valid ? pc_mem[head_q]   : 30'd0;

`ifdef IPQ_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(push);
        flush_count_d = flush_count_q + 32'(redirect);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
